// File: rtl/xadac_rsp_tracker.sv
// xadac_rsp_tracker: credit-gated request pass-through with an in-order response FIFO.
// A transaction holds a credit from request accept until its response is handed to the initiator.
// Each credit therefore also reserves a FIFO slot, and the FIFO cannot overflow.
module xadac_rsp_tracker #(
    parameter type         ReqT           = logic,
    parameter type         RspT           = logic,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic clk,
    input  logic rstn,
    input  ReqT  slv_req_data,
    input  logic slv_req_valid,
    output logic slv_req_ready,
    output ReqT  mst_req_data,
    output logic mst_req_valid,
    input  logic mst_req_ready,
    input  RspT  mst_rsp_data,
    input  logic mst_rsp_valid,
    output logic mst_rsp_ready,
    output RspT  slv_rsp_data,
    output logic slv_rsp_valid,
    input  logic slv_rsp_ready,
    output logic idle,
    output logic rsp_unexpected
);
    localparam int CW = $clog2(MaxOutstanding + 1);
    localparam int PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_fill;
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    RspT           r_mem [MaxOutstanding];
    logic          r_unexp;

    logic w_credit;
    logic w_fire;
    logic w_push;
    logic w_pop;
    logic w_empty;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(MaxOutstanding - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit uses only the registered count, so a pop never frees a slot in the same cycle.
    assign w_credit       = r_cnt < CW'(MaxOutstanding);
    assign slv_req_ready  = rstn & mst_req_ready & w_credit;
    assign mst_req_valid  = rstn & slv_req_valid & w_credit;
    assign mst_req_data   = slv_req_data;
    assign w_fire         = slv_req_valid & slv_req_ready;
    // Responses are always sunk; those arriving with nothing outstanding are dropped.
    assign mst_rsp_ready  = 1'b1;
    assign w_push         = mst_rsp_valid & (r_cnt != '0);
    assign w_empty        = r_fill == '0;
    assign slv_rsp_valid  = !w_empty;
    assign w_pop          = slv_rsp_valid & slv_rsp_ready;
    assign slv_rsp_data   = w_empty ? '0 : r_mem[r_rd];
    assign idle           = r_cnt == '0;
    assign rsp_unexpected = r_unexp;

    // Outstanding-transaction count and the dropped-response flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_unexp <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + CW'(w_fire) - CW'(w_pop);
            r_unexp <= mst_rsp_valid & (r_cnt == '0);
        end
    end

    // Circular response buffer; a written beat is visible the cycle after the write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fill <= '0;
            r_wr   <= '0;
            r_rd   <= '0;
            for (int i = 0; i < int'(MaxOutstanding); i++) r_mem[i] <= '0;
        end else begin
            r_fill <= r_fill + CW'(w_push) - CW'(w_pop);
            if (w_push) begin
                r_mem[r_wr] <= mst_rsp_data;
                r_wr        <= f_inc(r_wr);
            end
            if (w_pop) r_rd <= f_inc(r_rd);
        end
    end
endmodule

// File: tb/tb_xadac_rsp_tracker.sv
// tb_xadac_rsp_tracker: directed scenarios plus a random phase against a queue-based model.
module tb_xadac_rsp_tracker;
    localparam int MAXO = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] slv_req_data, mst_req_data, mst_rsp_data, slv_rsp_data;
    logic       slv_req_valid, slv_req_ready, mst_req_valid, mst_req_ready;
    logic       mst_rsp_valid, mst_rsp_ready, slv_rsp_valid, slv_rsp_ready;
    logic       idle, rsp_unexpected;

    int         checks = 0;
    int         failures = 0;
    int         m_cnt = 0;
    int         m_pend = 0;
    logic       m_unexp = 1'b0;
    logic [7:0] m_q[$];

    xadac_rsp_tracker #(
        .ReqT(logic [7:0]),
        .RspT(logic [7:0]),
        .MaxOutstanding(MAXO)
    ) u_dut (
        .clk(clk),
        .rstn(rstn),
        .slv_req_data(slv_req_data),
        .slv_req_valid(slv_req_valid),
        .slv_req_ready(slv_req_ready),
        .mst_req_data(mst_req_data),
        .mst_req_valid(mst_req_valid),
        .mst_req_ready(mst_req_ready),
        .mst_rsp_data(mst_rsp_data),
        .mst_rsp_valid(mst_rsp_valid),
        .mst_rsp_ready(mst_rsp_ready),
        .slv_rsp_data(slv_rsp_data),
        .slv_rsp_valid(slv_rsp_valid),
        .slv_rsp_ready(slv_rsp_ready),
        .idle(idle),
        .rsp_unexpected(rsp_unexpected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [7:0] rd, input logic mrr,
                         input logic pv, input logic [7:0] pd, input logic srr);
        slv_req_valid = rv;
        slv_req_data  = rd;
        mst_req_ready = mrr;
        mst_rsp_valid = pv;
        mst_rsp_data  = pd;
        slv_rsp_ready = srr;
    endtask

    // Compare every output against the model a little after the inputs settle.
    task automatic mcheck(input string t);
        #2;
        chk({t, ":mst_req_valid"}, mst_req_valid, slv_req_valid && m_cnt < MAXO);
        chk({t, ":slv_req_ready"}, slv_req_ready, mst_req_ready && m_cnt < MAXO);
        chk({t, ":mst_req_data"}, mst_req_data, slv_req_data);
        chk({t, ":mst_rsp_ready"}, mst_rsp_ready, 1);
        chk({t, ":slv_rsp_valid"}, slv_rsp_valid, m_q.size() != 0);
        chk({t, ":slv_rsp_data"}, slv_rsp_data, m_q.size() != 0 ? m_q[0] : 8'h00);
        chk({t, ":idle"}, idle, m_cnt == 0);
        chk({t, ":rsp_unexpected"}, rsp_unexpected, m_unexp);
    endtask

    // Advance one clock and apply the handshake rules to the model.
    task automatic tick();
        bit fire, pop, push, unx;
        fire = slv_req_valid && mst_req_ready && (m_cnt < MAXO);
        pop  = slv_rsp_ready && (m_q.size() != 0);
        push = mst_rsp_valid && (m_cnt > 0);
        unx  = mst_rsp_valid && (m_cnt == 0);
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(mst_rsp_data);
            m_pend--;
        end
        if (fire) m_pend++;
        m_cnt   = m_cnt + int'(fire) - int'(pop);
        m_unexp = unx;
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 8'h00, 1'b1, m_pend > 0, 8'h60 + 8'(i), 1'b1);
            mcheck("drain");
            tick();
        end
    endtask

    task automatic single_txn(input string t);
        drive(1'b1, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1);
        mcheck({t, "a"});
        chk({t, "_pass_valid"}, mst_req_valid, 1);
        chk({t, "_pass_data"}, mst_req_data, 8'h3C);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1);
        mcheck({t, "b"});
        chk({t, "_busy"}, idle, 0);
        chk({t, "_not_yet"}, slv_rsp_valid, 0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        mcheck({t, "c"});
        chk({t, "_rsp_valid"}, slv_rsp_valid, 1);
        chk({t, "_rsp_data"}, slv_rsp_data, 8'hA5);
        tick();
        mcheck({t, "d"});
        chk({t, "_idle"}, idle, 1);
        tick();
    endtask

    initial begin
        int r;
        int p;
        logic pv;
        // Reset state with live inputs.
        drive(1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);
        #1;
        chk("rst_slv_req_ready", slv_req_ready, 0);
        chk("rst_mst_req_valid", mst_req_valid, 0);
        chk("rst_mst_req_data", mst_req_data, 8'h5A);
        chk("rst_slv_rsp_valid", slv_rsp_valid, 0);
        chk("rst_slv_rsp_data", slv_rsp_data, 8'h00);
        chk("rst_idle", idle, 1);
        chk("rst_unexp", rsp_unexpected, 0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        // Single request/response round trip.
        single_txn("s1");
        // Fill all credits with the initiator stalled, then buffer all responses.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
            mcheck("s2req");
            if (i == 4) begin
                chk("s2_hold_ready", slv_req_ready, 0);
                chk("s2_hold_mvalid", mst_req_valid, 0);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h14, 1'b1, 1'b1, 8'h50 + 8'(i), 1'b0);
            mcheck("s2rsp");
            chk("s2_rsp_ready", mst_rsp_ready, 1);
            tick();
        end
        // A pop frees the credit only from the following cycle.
        drive(1'b1, 8'h14, 1'b1, 1'b0, 8'h00, 1'b1);
        mcheck("s3a");
        chk("s3_no_same_cycle", slv_req_ready, 0);
        chk("s3_head", slv_rsp_data, 8'h50);
        tick();
        drive(1'b1, 8'h14, 1'b1, 1'b0, 8'h00, 1'b0);
        mcheck("s3b");
        chk("s3_next_cycle", slv_req_ready, 1);
        tick();
        drain(6);
        // Steady streaming across pointer wrap.
        r = 0;
        p = 0;
        for (int k = 0; k < 22; k++) begin
            pv = m_pend > 0;
            drive(k < 20, 8'(k), 1'b1, pv, 8'(r), 1'b1);
            if (pv) r++;
            mcheck("s4");
            if (k >= 2 && k < 20) chk("s4_ready", slv_req_ready, 1);
            if (slv_rsp_valid) begin
                chk("s4_order", slv_rsp_data, p);
                p++;
            end
            tick();
        end
        drain(6);
        chk("s4_count", p + (m_q.size() == 0 ? 0 : 100), 20);
        // Response with nothing outstanding.
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'hEE, 1'b1);
        mcheck("s5a");
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        mcheck("s5b");
        chk("s5_unexp_hi", rsp_unexpected, 1);
        chk("s5_no_valid", slv_rsp_valid, 0);
        tick();
        mcheck("s5c");
        chk("s5_unexp_lo", rsp_unexpected, 0);
        tick();
        // Reset with three outstanding, two of them buffered.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
            mcheck("s6req");
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h70 + 8'(i), 1'b0);
            mcheck("s6rsp");
            tick();
        end
        drive(1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0);
        mcheck("s6pre");
        chk("s6_pre_valid", slv_rsp_valid, 1);
        rstn = 1'b0;
        #1;
        chk("s6_valid0", slv_rsp_valid, 0);
        chk("s6_idle1", idle, 1);
        chk("s6_req_ready0", slv_req_ready, 0);
        chk("s6_mreq_valid0", mst_req_valid, 0);
        m_q.delete();
        m_cnt   = 0;
        m_pend  = 0;
        m_unexp = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h77, 1'b1);
        mcheck("s6late");
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        mcheck("s6late2");
        chk("s6_late_unexp", rsp_unexpected, 1);
        chk("s6_late_dropped", slv_rsp_valid, 0);
        tick();
        single_txn("s6new");
        // Random traffic with a well-behaved accelerator and occasional stray responses.
        for (int k = 0; k < 400; k++) begin
            pv = (m_pend > 0) ? 1'($urandom_range(0, 1)) : (m_cnt == 0 && $urandom_range(0, 9) == 0);
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                  pv, 8'($urandom), 1'($urandom_range(0, 2) != 0));
            mcheck("rnd");
            tick();
        end
        drain(10);
        mcheck("end");
        chk("end_idle", idle, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
